// File: rtl/fifo_level_pkg.sv
// fifo_level_pkg: shared helpers and types for the fifo_level block.
//   cnt_width(depth) : width of an occupancy count that can hold 0..depth
//   ptr_width(depth) : width of an index that can hold 0..depth-1 (at least 1)
//   flags_t          : registered status flag bundle
//   FLAGS_RESET      : flag values right after reset (empty FIFO)
package fifo_level_pkg;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return ($clog2(depth) < 1) ? 1 : $clog2(depth);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } flags_t;

  localparam flags_t FLAGS_RESET = '{
    full:         1'b0,
    empty:        1'b1,
    almost_full:  1'b0,
    almost_empty: 1'b1
  };

endpackage

// File: rtl/fifo_level_ptr.sv
// fifo_level_ptr: wrap-around index 0..DEPTH-1 that advances when en is high.
// The wrap uses an explicit compare against DEPTH-1, so any DEPTH works,
// including non-powers-of-two.
// Ports:
//   clk  : clock, rising edge
//   rstn : synchronous active-low reset, clears ptr to 0
//   en   : advance the pointer this edge
//   ptr  : current pointer value
module fifo_level_ptr
  import fifo_level_pkg::*;
#(
  parameter int DEPTH = 5
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         en,
  output logic [ptr_width(DEPTH)-1:0]  ptr
);

  localparam int PW = ptr_width(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_level.sv
// fifo_level: parametrised single-clock FIFO with occupancy count,
// programmable almost-full/almost-empty flags and overflow/underflow pulses.
//
// Optional feature macro: FIFO_LEVEL_FWFT_EN
//   undefined : out is registered, loaded from the head entry on an accepted
//               pop (one cycle read latency), holds until the next accepted pop
//   defined   : first-word-fall-through, out shows the head entry
//               combinationally whenever the FIFO is not empty, 0 when empty
//
// Ports:
//   clk          : clock, rising edge
//   rstn         : synchronous active-low reset
//   push, data   : write request and write data
//   pop          : read request
//   out          : read data
//   full, empty  : count == DEPTH / count == 0
//   almost_full  : count >= AF_LEVEL
//   almost_empty : count <= AE_LEVEL
//   count        : current occupancy
//   overflow     : one-cycle pulse after a rejected push
//   underflow    : one-cycle pulse after a rejected pop
//
// Handshake: push and pop are requests; there is no separate ready. A pop is
// accepted when the FIFO is not empty. A push is accepted when the FIFO is not
// full, or when it is full and a pop is accepted in the same cycle. Both are
// judged on the state before the edge, so a push into an empty FIFO never makes
// a same-cycle pop legal. Rejected requests change no state and raise
// overflow/underflow for the following cycle.
module fifo_level
  import fifo_level_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 5,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             data,
  output logic [WIDTH-1:0]             out,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [cnt_width(DEPTH)-1:0]  count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int CW = cnt_width(DEPTH);
  localparam int PW = ptr_width(DEPTH);

  if (WIDTH < 1) begin : g_bad_width
    $error("fifo_level: WIDTH must be >= 1");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("fifo_level: DEPTH must be >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("fifo_level: AF_LEVEL must be in 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("fifo_level: AE_LEVEL must be in 0..DEPTH-1");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_nxt;
  flags_t           flags_q;
  flags_t           flags_nxt;
  logic             push_ok;
  logic             pop_ok;
  logic             overflow_q;
  logic             underflow_q;

  assign pop_ok  = pop && !flags_q.empty;
  assign push_ok = push && (!flags_q.full || pop_ok);

  fifo_level_ptr #(.DEPTH(DEPTH)) u_wp (
    .clk  (clk),
    .rstn (rstn),
    .en   (push_ok),
    .ptr  (wp)
  );

  fifo_level_ptr #(.DEPTH(DEPTH)) u_rp (
    .clk  (clk),
    .rstn (rstn),
    .en   (pop_ok),
    .ptr  (rp)
  );

  // Storage is deliberately not reset; requests are ignored during reset.
  always_ff @(posedge clk) begin
    if (rstn && push_ok) begin
      mem[wp] <= data;
    end
  end

  // Flags are computed from the next count so they move on the same edge as count.
  always_comb begin
    count_nxt = count_q;
    if (push_ok && !pop_ok) begin
      count_nxt = count_q + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_nxt = count_q - CW'(1);
    end
    flags_nxt.full         = (count_nxt == CW'(DEPTH));
    flags_nxt.empty        = (count_nxt == '0);
    flags_nxt.almost_full  = (count_nxt >= CW'(AF_LEVEL));
    flags_nxt.almost_empty = (count_nxt <= CW'(AE_LEVEL));
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_q     <= '0;
      flags_q     <= FLAGS_RESET;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_nxt;
      flags_q     <= flags_nxt;
      overflow_q  <= push && !push_ok;
      underflow_q <= pop && !pop_ok;
    end
  end

`ifdef FIFO_LEVEL_FWFT_EN
  assign out = flags_q.empty ? '0 : mem[rp];
`else
  logic [WIDTH-1:0] out_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_q <= '0;
    end else if (pop_ok) begin
      out_q <= mem[rp];
    end
  end

  assign out = out_q;
`endif

  assign count        = count_q;
  assign full         = flags_q.full;
  assign empty        = flags_q.empty;
  assign almost_full  = flags_q.almost_full;
  assign almost_empty = flags_q.almost_empty;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_level.sv
// tb_fifo_level: randomized and directed stimulus for fifo_level, checked
// against a queue-based reference model through an expected-response queue.
module tb_fifo_level;
  import fifo_level_pkg::*;

  localparam int WIDTH    = 4;
  localparam int DEPTH    = 5;
  localparam int AF_LEVEL = DEPTH - 1;
  localparam int AE_LEVEL = 1;
  localparam int CW       = cnt_width(DEPTH);

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic [WIDTH-1:0] data = '0;
  logic [WIDTH-1:0] out;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  always #5 clk = ~clk;

  fifo_level #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF_LEVEL),
    .AE_LEVEL (AE_LEVEL)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .push         (push),
    .pop          (pop),
    .data         (data),
    .out          (out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed {
    logic [WIDTH-1:0] out;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             af;
    logic             ae;
    logic             ov;
    logic             un;
  } exp_t;

  localparam int EXP_W = $bits(exp_t);

  logic [EXP_W-1:0] exp_q[$];
  int               model_q[$];
  logic [WIDTH-1:0] model_out = '0;
  int               tests = 0;
  int               fails = 0;

  // ---------------- driver ----------------
  // Applies one cycle of inputs and predicts the outputs seen after that edge.
  task automatic drive(input logic r, input logic pu, input logic po,
                       input logic [WIDTH-1:0] d);
    exp_t e;
    bit   pop_ok;
    bit   push_ok;
    int   sz;
    @(negedge clk);
    rstn = r;
    push = pu;
    pop  = po;
    data = d;
    e = '0;
    if (!r) begin
      model_q.delete();
      model_out = '0;
    end else begin
      sz      = model_q.size();
      pop_ok  = po && (sz > 0);
      push_ok = pu && ((sz < DEPTH) || pop_ok);
      e.ov    = pu && !push_ok;
      e.un    = po && !pop_ok;
      if (pop_ok) model_out = WIDTH'(model_q.pop_front());
      if (push_ok) model_q.push_back(int'(d));
    end
    sz      = model_q.size();
    e.count = CW'(sz);
    e.full  = (sz == DEPTH);
    e.empty = (sz == 0);
    e.af    = (sz >= AF_LEVEL);
    e.ae    = (sz <= AE_LEVEL);
`ifdef FIFO_LEVEL_FWFT_EN
    e.out   = (sz > 0) ? WIDTH'(model_q[0]) : '0;
`else
    e.out   = model_out;
`endif
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // ---------------- monitor ----------------
  exp_t mon_e;

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("out",          32'(out),          32'(mon_e.out));
      chk("count",        32'(count),        32'(mon_e.count));
      chk("full",         32'(full),         32'(mon_e.full));
      chk("empty",        32'(empty),        32'(mon_e.empty));
      chk("almost_full",  32'(almost_full),  32'(mon_e.af));
      chk("almost_empty", 32'(almost_empty), 32'(mon_e.ae));
      chk("overflow",     32'(overflow),     32'(mon_e.ov));
      chk("underflow",    32'(underflow),    32'(mon_e.un));
      tests++;
      if (!(count <= CW'(DEPTH))) begin
        fails++;
        $display("FAIL count_bound: got %0d expected <= %0d at %0t", count, DEPTH, $time);
      end
    end
  end

  // ---------------- stimulus ----------------
  int pp;
  int pq;

  initial begin
    drive(1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, 1'b1, 4'd3);

    // fill past full, then drain past empty
    for (int i = 1; i <= 6; i++) drive(1'b1, 1'b1, 1'b0, WIDTH'(i));
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 1'b1, '0);

    // full with simultaneous push+pop, then drain
    for (int i = 1; i <= 5; i++) drive(1'b1, 1'b1, 1'b0, WIDTH'(i));
    drive(1'b1, 1'b1, 1'b1, 4'd9);
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 1'b1, '0);

    // push+pop on empty: pop rejected, push accepted
    drive(1'b1, 1'b1, 1'b1, 4'd7);
    drive(1'b1, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b1, '0);

    // reset mid-stream with count = 3; old data must never come back
    for (int i = 10; i < 13; i++) drive(1'b1, 1'b1, 1'b0, WIDTH'(i));
    drive(1'b0, 1'b1, 1'b1, 4'd5);
    drive(1'b1, 1'b0, 1'b1, '0);
    drive(1'b1, 1'b0, 1'b1, '0);

    // random phases with varying push/pop bias, many pointer wraps
    for (int ph = 0; ph < 6; ph++) begin
      pp = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 50 : 25;
      pq = (ph % 3 == 0) ? 30 : (ph % 3 == 1) ? 50 : 75;
      for (int i = 0; i < 120; i++) begin
        drive(($urandom_range(0, 149) != 0),
              ($urandom_range(0, 99) < pp),
              ($urandom_range(0, 99) < pq),
              WIDTH'($urandom_range(0, (1 << WIDTH) - 1)));
      end
    end

    drive(1'b1, 1'b0, 1'b0, '0);
    repeat (2) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
